icache_assoc: RTL and testbench

Parametrised set-associative instruction cache. It replaces the direct-mapped, one-word-per-line instruction cache between the datapath fetch port and the memory-controller instruction port. It generalises associativity, set count and block size, and adds multi-word block fill, round-robin victim selection, a flush input and a miss counter. Hits are returned combinationally in the request cycle; misses stall the datapath until the whole block is installed.

---
 rtl/icache_assoc_if.sv | 24 ++
 rtl/icache_assoc.sv | 177 +++++++++++++++++
 tb/tb_icache_assoc.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for port lists.
// The cache takes the slave view; the datapath/memory side takes the master view.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr, miss_count
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, miss_count
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hits, multi-word block fill on miss,
// round-robin victim per set, synchronous flush and a free-running miss counter.
module icache_assoc #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  icache_assoc_if.slave bus
);

  localparam int WB    = $clog2(WORDS);
  localparam int IB    = $clog2(SETS);
  localparam int TAG_W = 30 - WB - IB;
  localparam int OW    = (WB > 0) ? WB : 1;
  localparam int PW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [31:0]   BLK_MASK = 32'(WORDS * 4 - 1);
  localparam logic [OW-1:0] LAST     = OW'(WORDS - 1);

  typedef enum logic {S_COMPARE, S_FILL} state_e;

  state_e                               state_q, state_d;
  logic [WAYS-1:0][SETS-1:0]            valid_q, valid_d;
  logic [WAYS-1:0][SETS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [SETS-1:0][PW-1:0]              ptr_q, ptr_d;
  logic [OW-1:0]                        cnt_q, cnt_d;
  logic [31:0]                          base_q, base_d;
  logic [WORDS-1:0][31:0]               fill_q, fill_d;
  logic [31:0]                          miss_q, miss_d;
  logic [31:0]                          data_mem [WAYS][SETS][WORDS];

  function automatic logic [OW-1:0] woff_of(logic [31:0] a);
    return OW'((a >> 2) & 32'(WORDS - 1));
  endfunction

  function automatic logic [IB-1:0] idx_of(logic [31:0] a);
    return IB'((a >> (2 + WB)) & 32'(SETS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(logic [31:0] a);
    return TAG_W'(a >> (2 + WB + IB));
  endfunction

  logic [IB-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OW-1:0]    req_woff;
  logic             hit;
  logic [PW-1:0]    hit_way, victim, victim_next;
  logic [31:0]      hit_word;
  logic             install;
  logic             ihit, iren;
  logic [31:0]      imemload, iaddr;

  assign req_idx  = idx_of(bus.imemaddr);
  assign req_tag  = tag_of(bus.imemaddr);
  assign req_woff = woff_of(bus.imemaddr);
  assign fill_idx = idx_of(base_q);

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = PW'(w);
      end
    end
  end

  assign hit_word = data_mem[hit_way][req_idx][req_woff];

  // Lowest invalid way wins; the descending scan leaves the smallest index last.
  always_comb begin
    victim = ptr_q[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][fill_idx]) victim = PW'(w);
    end
    victim_next = PW'((32'(victim) + 32'd1) % 32'(WAYS));
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    fill_d   = fill_q;
    miss_d   = miss_q;
    install  = 1'b0;
    ihit     = 1'b0;
    imemload = '0;
    iren     = 1'b0;
    iaddr    = '0;

    case (state_q)
      S_COMPARE: begin
        if (bus.imemREN && !bus.iflush) begin
          if (hit) begin
            ihit     = 1'b1;
            imemload = hit_word;
          end else begin
            miss_d  = miss_q + 32'd1;
            base_d  = bus.imemaddr & ~BLK_MASK;
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        iren  = 1'b1;
        iaddr = base_q + (32'(cnt_q) << 2);
        if (!bus.iwait) begin
          fill_d[cnt_q] = bus.iload;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            install                   = 1'b1;
            valid_d[victim][fill_idx] = 1'b1;
            tag_d[victim][fill_idx]   = tag_of(base_q);
            ptr_d[fill_idx]           = victim_next;
            cnt_d                     = '0;
            state_d                   = S_COMPARE;
          end
        end
      end
      default: state_d = S_COMPARE;
    endcase

    // Flush overrides hits and a same-cycle final-word install; the miss counter is untouched.
    if (bus.iflush) begin
      valid_d = '0;
      ptr_d   = '0;
      cnt_d   = '0;
      install = 1'b0;
      state_d = S_COMPARE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_COMPARE;
      valid_q <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      fill_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      fill_q  <= fill_d;
      miss_q  <= miss_d;
    end
  end

  // NOTE: the data array has no reset; the valid bits already make stale contents unobservable.
  always_ff @(posedge CLK) begin
    if (install) begin
      for (int k = 0; k < WORDS; k++) data_mem[victim][fill_idx][k] <= fill_d[k];
    end
  end

  assign bus.ihit       = ihit;
  assign bus.imemload   = imemload;
  assign bus.iREN       = iren;
  assign bus.iaddr      = iaddr;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboarded bench for icache_assoc: a behavioural cache model predicts hit/miss, data,
// latency and fill addresses; a memory responder and a fetch monitor check the DUT.
module tb_icache_assoc;
  localparam int WAYS  = 2;
  localparam int SETS  = 8;
  localparam int WORDS = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  icache_assoc_if bus();

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  exp_t        exp_q[$];
  logic [31:0] fill_addr_q[$];
  int          req_cyc  = 0;
  bit          done     = 1'b0;
  int          wpw      = 0;
  bit          free_mem = 1'b0;

  bit          m_valid [WAYS][SETS];
  int unsigned m_tag   [WAYS][SETS];
  int          m_ptr   [SETS];
  int unsigned m_misses = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void model_clear();
    foreach (m_valid[w, s]) m_valid[w][s] = 1'b0;
    foreach (m_ptr[s]) m_ptr[s] = 0;
  endfunction

  // Returns 1 on hit; on miss installs the block by the replacement rules and counts the miss.
  function automatic bit model_access(logic [31:0] a);
    int unsigned blk, set, tag;
    int way;
    blk = a / (4 * WORDS);
    set = blk % SETS;
    tag = blk / SETS;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][set] && m_tag[w][set] == tag) return 1'b1;
    m_misses++;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[w][set]) way = w;
    if (way < 0) way = m_ptr[set];
    m_valid[way][set] = 1'b1;
    m_tag[way][set]   = tag;
    m_ptr[set]        = (way + 1) % WAYS;
    return 1'b0;
  endfunction

  // Issue one fetch at posedge+1 and hold it until the monitor reports the hit.
  task automatic fetch(input logic [31:0] a, input bit distract);
    bit          hit;
    exp_t        e;
    int unsigned base;
    hit = model_access(a);
    e.addr = a;
    e.data = mem_word(a);
    e.lat  = hit ? 0 : 1 + WORDS * (wpw + 1);
    if (!hit) begin
      base = (a / (4 * WORDS)) * (4 * WORDS);
      for (int k = 0; k < WORDS; k++) fill_addr_q.push_back(32'(base + 4 * k));
    end
    exp_q.push_back(e);
    done         = 1'b0;
    req_cyc      = cyc;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    for (int k = 0; k < e.lat + 20 && !done; k++) begin
      @(posedge CLK);
      #1;
      if (!done)
        bus.imemaddr = (distract && (cyc - req_cyc) < e.lat) ? 32'($urandom_range(0, 255) * 4) : a;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_timeout: addr 0x%08h got no hit, required hit within %0d cycles", a, e.lat);
      exp_q.delete();
      fill_addr_q.delete();
    end
    check("miss_count", bus.miss_count, m_misses);
  endtask

  // Fetch monitor: every presented hit is matched against the oldest expectation.
  exp_t mon_e;
  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.ihit) begin
        if (!bus.imemREN) begin
          check("ihit_without_request", 32'(bus.ihit), 32'd0);
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_hit: addr 0x%08h got ihit=1 required 0", bus.imemaddr);
        end else begin
          mon_e = exp_q.pop_front();
          check("hit_addr", bus.imemaddr, mon_e.addr);
          check("imemload", bus.imemload, mon_e.data);
          check("hit_latency", 32'(cyc - req_cyc), 32'(mon_e.lat));
          done = 1'b1;
        end
      end else if (bus.imemload !== 32'd0) begin
        check("imemload_when_no_hit", bus.imemload, 32'd0);
      end
    end
  end

  // Memory responder: wpw wait cycles per word; checks fill order and iaddr stability.
  int          wcnt = 0;
  logic [31:0] held = '0;
  always @(posedge CLK) begin
    #2;
    if (!nRST || !bus.iREN) begin
      bus.iwait = 1'b0;
      bus.iload = $urandom;
      wcnt      = 0;
    end else begin
      if (wcnt > 0) check("iaddr_stable", bus.iaddr, held);
      if (wcnt < wpw) begin
        bus.iwait = 1'b1;
        held      = bus.iaddr;
        wcnt++;
      end else begin
        bus.iwait = 1'b0;
        bus.iload = mem_word(bus.iaddr);
        wcnt      = 0;
        if (!free_mem) begin
          if (fill_addr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_iREN: iaddr 0x%08h got iREN=1 required 0", bus.iaddr);
          end else begin
            check("fill_iaddr", bus.iaddr, fill_addr_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.iflush   = 1'b0;
    bus.iwait    = 1'b0;
    bus.iload    = '0;
    model_clear();
    #3;
    check("rst_ihit", 32'(bus.ihit), 32'd0);
    check("rst_imemload", bus.imemload, 32'd0);
    check("rst_iREN", 32'(bus.iREN), 32'd0);
    check("rst_iaddr", bus.iaddr, 32'd0);
    check("rst_miss_count", bus.miss_count, 32'd0);
    bus.imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;

    // First miss, hit on the neighbouring word, then set-0 round-robin eviction.
    wpw = 0;
    fetch(32'h40, 1'b0);
    fetch(32'h44, 1'b0);
    fetch(32'h80, 1'b0);
    fetch(32'hC0, 1'b0);
    fetch(32'h80, 1'b0);
    fetch(32'h40, 1'b0);
    check("miss_count_after_eviction", bus.miss_count, 32'd4);

    // Slow memory, then a fill with the fetch address wandering.
    wpw = 3;
    fetch(32'h100, 1'b0);
    wpw = 1;
    fetch(32'h208, 1'b1);
    fetch(32'h20C, 1'b0);

    // Flush while a resident address is requested: no hit.
    bus.imemaddr = 32'h208;
    bus.iflush   = 1'b1;
    @(negedge CLK);
    check("ihit_during_flush", 32'(bus.ihit), 32'd0);
    @(posedge CLK);
    #1;
    bus.iflush  = 1'b0;
    bus.imemREN = 1'b0;
    model_clear();

    // Flush in the first FILL cycle aborts the fill.
    free_mem     = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h208;
    m_misses++;
    @(negedge CLK);
    check("flush_test_miss", 32'(bus.ihit), 32'd0);
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
    bus.iflush  = 1'b1;
    @(negedge CLK);
    check("iREN_in_fill", 32'(bus.iREN), 32'd1);
    @(posedge CLK);
    #1;
    bus.iflush = 1'b0;
    @(negedge CLK);
    check("iREN_after_flush", 32'(bus.iREN), 32'd0);
    check("miss_count_after_flush", bus.miss_count, m_misses);
    @(posedge CLK);
    #1;
    free_mem = 1'b0;
    fetch(32'h208, 1'b0);

    // Reset dropped mid-fill.
    free_mem     = 1'b1;
    bus.imemaddr = 32'h300;
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("midrst_ihit", 32'(bus.ihit), 32'd0);
    check("midrst_imemload", bus.imemload, 32'd0);
    check("midrst_iREN", 32'(bus.iREN), 32'd0);
    check("midrst_iaddr", bus.iaddr, 32'd0);
    check("midrst_miss_count", bus.miss_count, 32'd0);
    @(negedge CLK);
    #1 nRST = 1'b1;
    model_clear();
    m_misses = 0;
    @(posedge CLK);
    #1;
    free_mem = 1'b0;
    fetch(32'h300, 1'b0);

    // Randomised traffic with idle cycles and occasional flushes.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        bus.imemREN = 1'b0;
        @(posedge CLK);
        #1;
      end else if (r == 1) begin
        bus.imemREN = 1'b0;
        bus.iflush  = 1'b1;
        @(posedge CLK);
        #1;
        bus.iflush = 1'b0;
        model_clear();
      end else begin
        wpw = $urandom_range(0, 2);
        fetch(32'($urandom_range(0, 127) * 4), ($urandom_range(0, 3) == 0));
      end
    end

    bus.imemREN = 1'b0;
    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
